// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, FSM state type and error-code bit positions.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [47:0] ETH_BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    // out_err_code = {filt, len, crc, rxer}
    localparam int ERR_RXER = 0;
    localparam int ERR_CRC  = 1;
    localparam int ERR_LEN  = 2;
    localparam int ERR_FILT = 3;

    // Byte idx of a MAC address in wire order (idx 0 = bits [47:40]).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        return mac[47 - 8 * int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC32 next-state for one byte. The register is kept in
// MSB-first orientation with data bits fed LSB first, so a good frame leaves 0xC704DD7B.
module eth_crc32_d8 (
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[31] ^ data[i])
                crc_next = {crc_next[30:0], 1'b0} ^ 32'h04C11DB7;
            else
                crc_next = {crc_next[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/eth_gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks CRC and length, drops the FCS.
// Define RX_MAC_FILTER_EN to flag frames whose DA is neither LOCAL_MAC nor broadcast.
module eth_gmii_rx_framer
    import eth_pkg::*;
#(
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518,
    parameter int          STAT_W    = 16,
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0
) (
    input  logic              gmii_rx_clk,
    input  logic              rst_n,
    input  logic [7:0]        gmii_rxd,
    input  logic              gmii_rx_dv,
    input  logic              gmii_rx_er,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_err,
    output logic [3:0]        out_err_code,
    output logic [STAT_W-1:0] stat_ok,
    output logic [STAT_W-1:0] stat_crc_err,
    output logic [STAT_W-1:0] stat_len_err
);

    localparam logic [11:0]       MIN_L    = 12'(MIN_LEN);
    localparam logic [11:0]       MAX_L    = 12'(MAX_LEN);
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    rx_state_t       state;
    logic [31:0]     crc;
    logic [31:0]     crc_next;
    logic [11:0]     len;
    logic [4:0][7:0] dly;
    logic [2:0]      fill;
    logic            sof_pend;
    logic            rxer;
    logic            crc_bad;
    logic            len_bad;
    logic            filt;
    logic [3:0]      err_code;

    eth_crc32_d8 u_crc (
        .crc      (crc),
        .data     (gmii_rxd),
        .crc_next (crc_next)
    );

`ifdef RX_MAC_FILTER_EN
    logic da_local;
    logic da_bcast;

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            da_local <= 1'b0;
            da_bcast <= 1'b0;
        end else if (state != DATA) begin
            da_local <= 1'b1;
            da_bcast <= 1'b1;
        end else if (gmii_rx_dv && len < 12'd6) begin
            if (gmii_rxd != mac_byte(LOCAL_MAC, len[2:0]))     da_local <= 1'b0;
            if (gmii_rxd != mac_byte(ETH_BCAST_MAC, len[2:0])) da_bcast <= 1'b0;
        end
    end

    assign filt = !(da_local || da_bcast);
`else
    logic unused_mac;
    assign unused_mac = ^LOCAL_MAC;
    assign filt       = 1'b0;
`endif

    always_comb begin
        crc_bad            = (crc != ETH_CRC_RESIDUE);
        len_bad            = (len < MIN_L) || (len > MAX_L);
        err_code           = 4'b0000;
        err_code[ERR_RXER] = rxer;
        err_code[ERR_CRC]  = crc_bad;
        err_code[ERR_LEN]  = len_bad;
        err_code[ERR_FILT] = filt;
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            crc          <= '1;
            len          <= '0;
            dly          <= '0;
            fill         <= '0;
            sof_pend     <= 1'b0;
            rxer         <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            out_err      <= 1'b0;
            out_err_code <= '0;
            stat_ok      <= '0;
            stat_crc_err <= '0;
            stat_len_err <= '0;
        end else begin
            out_valid    <= 1'b0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            out_err      <= 1'b0;
            out_err_code <= '0;
            // Frame context is re-armed every cycle outside DATA.
            if (state != DATA) begin
                crc      <= '1;
                len      <= '0;
                fill     <= '0;
                rxer     <= 1'b0;
                sof_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == ETH_PREAMBLE) state <= PREAMBLE;
                        else if (gmii_rxd == ETH_SFD) state <= DATA;
                        else                          state <= DROP;
                    end
                end
                PREAMBLE: begin
                    if (!gmii_rx_dv)                  state <= IDLE;
                    else if (gmii_rxd == ETH_SFD)     state <= DATA;
                    else if (gmii_rxd != ETH_PREAMBLE) state <= DROP;
                end
                DATA: begin
                    if (gmii_rx_dv) begin
                        crc <= crc_next;
                        if (len != 12'hFFF) len <= len + 12'd1;
                        dly <= {dly[3:0], gmii_rxd};
                        if (gmii_rx_er) rxer <= 1'b1;
                        if (fill == 3'd5) begin
                            out_valid <= 1'b1;
                            out_data  <= dly[4];
                            out_sof   <= sof_pend;
                            sof_pend  <= 1'b0;
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end else begin
                        state <= IDLE;
                        // The four youngest bytes are the FCS and are dropped here.
                        if (len > 12'd5) begin
                            out_valid    <= 1'b1;
                            out_data     <= dly[4];
                            out_sof      <= sof_pend;
                            out_eof      <= 1'b1;
                            out_err      <= |err_code;
                            out_err_code <= err_code;
                            if (err_code == 4'b0000 && stat_ok != '1)
                                stat_ok <= stat_ok + STAT_ONE;
                            if (crc_bad && stat_crc_err != '1)
                                stat_crc_err <= stat_crc_err + STAT_ONE;
                            if (len_bad && stat_len_err != '1)
                                stat_len_err <= stat_len_err + STAT_ONE;
                        end else if (stat_len_err != '1) begin
                            stat_len_err <= stat_len_err + STAT_ONE;
                        end
                    end
                end
                DROP: begin
                    if (!gmii_rx_dv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_gmii_rx_framer.sv
// Randomised bench for eth_gmii_rx_framer with a frame-level reference model.
module tb_eth_gmii_rx_framer;

    localparam logic [47:0] LOCAL_MAC = 48'h000A3501FEC0;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rxd;
    logic        dv;
    logic        er;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        out_err;
    logic [3:0]  out_err_code;
    logic [15:0] stat_ok;
    logic [15:0] stat_crc_err;
    logic [15:0] stat_len_err;

    int checks = 0;
    int errors = 0;

    // Beat = {sof, eof, err, err_code[3:0], data[7:0]}; err fields zero except on eof.
    logic [14:0] exp_q[$];
    logic [14:0] got_q[$];
    logic [7:0]  frame_q[$];
    logic [15:0] m_ok, m_crc, m_len;

    eth_gmii_rx_framer dut (
        .gmii_rx_clk  (clk),
        .rst_n        (rst_n),
        .gmii_rxd     (rxd),
        .gmii_rx_dv   (dv),
        .gmii_rx_er   (er),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .out_err      (out_err),
        .out_err_code (out_err_code),
        .stat_ok      (stat_ok),
        .stat_crc_err (stat_crc_err),
        .stat_len_err (stat_len_err)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid)
            got_q.push_back({out_sof, out_eof, (out_eof ? {out_err, out_err_code} : 5'b0), out_data});
    end

    // Standard bit-serial reflected CRC32 over the first n bytes of frame_q.
    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frame_q[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int n_pay, input logic [47:0] da);
        logic [31:0] fcs;
        frame_q.delete();
        for (int i = 0; i < n_pay; i++)
            frame_q.push_back(i < 6 ? da[47 - 8*i -: 8] : 8'($urandom_range(0, 255)));
        fcs = crc_ref(n_pay);
        for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
    endtask

    task automatic build_raw(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Expected beats and counters for frame_q as the frame received after the SFD.
    task automatic model_frame(input bit er_hit);
        int          n;
        int          npay;
        logic [31:0] fcs_rx;
        logic [47:0] da;
        logic        crc_f, len_f, filt;
        logic [3:0]  code;
        n = frame_q.size();
        if (n <= 5) begin
            m_len++;
        end else begin
            npay   = n - 4;
            fcs_rx = {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
            crc_f  = (crc_ref(npay) != fcs_rx);
            len_f  = (n < 64) || (n > 1518);
            da     = '0;
            for (int i = 0; i < 6; i++) da = {da[39:0], frame_q[i]};
`ifdef RX_MAC_FILTER_EN
            filt = (da != LOCAL_MAC) && (da != 48'hFFFF_FFFF_FFFF);
`else
            filt = (da == 48'h0) && 1'b0;
`endif
            code = {filt, len_f, crc_f, er_hit};
            for (int k = 0; k < npay; k++)
                exp_q.push_back({k == 0, k == npay - 1,
                                 (k == npay - 1) ? {|code, code} : 5'b0, frame_q[k]});
            if (code == 4'b0) m_ok++;
            if (crc_f) m_crc++;
            if (len_f) m_len++;
        end
    endtask

    task automatic send_frame(input int npre, input int er_idx);
        for (int i = 0; i < npre; i++) begin
            @(negedge clk); dv = 1'b1; rxd = 8'h55; er = 1'b0;
        end
        @(negedge clk); dv = 1'b1; rxd = 8'hD5; er = 1'b0;
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk); rxd = frame_q[i]; er = (i == er_idx);
        end
        @(negedge clk); dv = 1'b0; rxd = 8'h00; er = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dv = 1'b0; er = 1'b0; rxd = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_sof, out_eof, out_err, out_err_code, out_data} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {out_valid, out_sof, out_eof, out_err, out_err_code, out_data});
        end
        checks++;
        if ({stat_ok, stat_crc_err, stat_len_err} !== 48'h0) begin
            errors++;
            $display("FAIL reset_stats got %h exp 0", {stat_ok, stat_crc_err, stat_len_err});
        end
        m_ok = 0; m_crc = 0; m_len = 0;
        @(negedge clk); rst_n = 1'b1;
        settle();
    endtask

    task automatic test_good();
        exp_q.delete(); got_q.delete();
        build_frame(60, LOCAL_MAC);
        model_frame(1'b0);
        send_frame(7, -1);
        settle();
        checks++;
        if (got_q.size() != 60) begin
            errors++; $display("FAIL good_beats got %0d exp 60", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL good_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stat_ok !== 16'd1 || {stat_ok, stat_crc_err, stat_len_err} !== {m_ok, m_crc, m_len}) begin
            errors++;
            $display("FAIL good_stats got %h exp %h", {stat_ok, stat_crc_err, stat_len_err}, {m_ok, m_crc, m_len});
        end
    endtask

    task automatic test_crc_err();
        exp_q.delete(); got_q.delete();
        build_frame(60, LOCAL_MAC);
        frame_q[10 + $urandom_range(0, 49)] ^= 8'(1 << $urandom_range(0, 7));
        model_frame(1'b0);
        send_frame(7, -1);
        settle();
        checks++;
        if (got_q.size() != 60 || got_q[59][12:8] !== 5'b10010) begin
            errors++;
            $display("FAIL crc_eof got n=%0d last=%h exp n=60 code=0010", got_q.size(),
                     (got_q.size() > 0) ? got_q[got_q.size()-1] : 15'h0);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL crc_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({stat_ok, stat_crc_err, stat_len_err} !== {m_ok, m_crc, m_len}) begin
            errors++;
            $display("FAIL crc_stats got %h exp %h", {stat_ok, stat_crc_err, stat_len_err}, {m_ok, m_crc, m_len});
        end
    endtask

    task automatic test_length();
        int lens[8] = '{0, 3, 5, 40, 63, 64, 1518, 1519};
        exp_q.delete(); got_q.delete();
        for (int t = 0; t < 8; t++) begin
            if (lens[t] <= 5) build_raw(lens[t]);
            else              build_frame(lens[t] - 4, LOCAL_MAC);
            model_frame(1'b0);
            send_frame(7, -1);
        end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL len_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL len_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({stat_ok, stat_crc_err, stat_len_err} !== {m_ok, m_crc, m_len}) begin
            errors++;
            $display("FAIL len_stats got %h exp %h", {stat_ok, stat_crc_err, stat_len_err}, {m_ok, m_crc, m_len});
        end
    endtask

    task automatic test_rxer();
        exp_q.delete(); got_q.delete();
        build_frame(60, LOCAL_MAC);
        model_frame(1'b1);
        send_frame(7, 20);
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rxer_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rxer_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({stat_ok, stat_crc_err, stat_len_err} !== {m_ok, m_crc, m_len}) begin
            errors++;
            $display("FAIL rxer_stats got %h exp %h", {stat_ok, stat_crc_err, stat_len_err}, {m_ok, m_crc, m_len});
        end
    endtask

    task automatic test_bad_preamble();
        logic [7:0] pre[3] = '{8'h55, 8'h55, 8'h5A};
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); dv = 1'b1; rxd = pre[i];
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); rxd = 8'($urandom_range(0, 255));
        end
        @(negedge clk); dv = 1'b0; rxd = 8'h00;
        build_frame(60, LOCAL_MAC);
        model_frame(1'b0);
        send_frame(7, -1);
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL badpre_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL badpre_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({stat_ok, stat_crc_err, stat_len_err} !== {m_ok, m_crc, m_len}) begin
            errors++;
            $display("FAIL badpre_stats got %h exp %h", {stat_ok, stat_crc_err, stat_len_err}, {m_ok, m_crc, m_len});
        end
    endtask

    task automatic test_back_to_back();
        int          n_tot;
        int          er_idx;
        logic [47:0] da;
        exp_q.delete(); got_q.delete();
        for (int f = 0; f < 12; f++) begin
            case ($urandom_range(0, 2))
                0:       da = LOCAL_MAC;
                1:       da = 48'hFFFF_FFFF_FFFF;
                default: da = {$urandom(), 16'($urandom())};
            endcase
            n_tot = $urandom_range(7, 150);
            build_frame(n_tot - 4, da);
            if ($urandom_range(0, 3) == 0)
                frame_q[$urandom_range(0, n_tot - 1)] ^= 8'(1 << $urandom_range(0, 7));
            er_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n_tot - 1) : -1;
            model_frame(er_idx >= 0);
            send_frame($urandom_range(0, 7), er_idx);
        end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({stat_ok, stat_crc_err, stat_len_err} !== {m_ok, m_crc, m_len}) begin
            errors++;
            $display("FAIL b2b_stats got %h exp %h", {stat_ok, stat_crc_err, stat_len_err}, {m_ok, m_crc, m_len});
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete(); got_q.delete();
        build_frame(60, LOCAL_MAC);
        for (int i = 30; i < 64; i++)
            if (frame_q[i] == 8'h55 || frame_q[i] == 8'hD5) frame_q[i] = 8'h00;
        // Bytes 0..29 sampled before reset: payload bytes 0..24 come out.
        for (int k = 0; k < 25; k++) exp_q.push_back({k == 0, 1'b0, 5'b0, frame_q[k]});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); dv = 1'b1; rxd = 8'h55;
        end
        @(negedge clk); rxd = 8'hD5;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); rxd = frame_q[i];
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sof, out_eof, out_err, out_err_code} !== 8'h0 ||
            {stat_ok, stat_crc_err, stat_len_err} !== 48'h0) begin
            errors++;
            $display("FAIL midrst_outputs got v=%b eof=%b stats=%h exp 0", out_valid, out_eof,
                     {stat_ok, stat_crc_err, stat_len_err});
        end
        m_ok = 0; m_crc = 0; m_len = 0;
        for (int i = 30; i < 64; i++) begin
            @(negedge clk); rxd = frame_q[i];
            if (i == 31) rst_n = 1'b1;
        end
        @(negedge clk); dv = 1'b0; rxd = 8'h00;
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL midrst_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({stat_ok, stat_crc_err, stat_len_err} !== 48'h0) begin
            errors++; $display("FAIL midrst_stats got %h exp 0", {stat_ok, stat_crc_err, stat_len_err});
        end
    endtask

    task automatic test_filter();
        exp_q.delete(); got_q.delete();
        build_frame(60, LOCAL_MAC);
        model_frame(1'b0);
        send_frame(7, -1);
        build_frame(60, 48'h0200_0000_0001);
        model_frame(1'b0);
        send_frame(7, -1);
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL filt_beats got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL filt_beat[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({stat_ok, stat_crc_err, stat_len_err} !== {m_ok, m_crc, m_len}) begin
            errors++;
            $display("FAIL filt_stats got %h exp %h", {stat_ok, stat_crc_err, stat_len_err}, {m_ok, m_crc, m_len});
        end
    endtask

    initial begin
        rst_n = 1'b0; dv = 1'b0; er = 1'b0; rxd = 8'h00;
        m_ok = 0; m_crc = 0; m_len = 0;
        test_reset();
        test_good();
        test_crc_err();
        test_length();
        test_rxer();
        test_bad_preamble();
        test_back_to_back();
        test_reset_mid();
        test_filter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
